stream_window_gen: RTL and testbench
====================================

Name: stream_window_gen

Overview:
- Parametrised successor to the fixed 3x3 line-buffer controller feeding the gaussian/sobel/nms/edge_track chain.
- Takes an AXI-stream pixel stream with start-of-frame (tuser) and end-of-line (tlast) markers, and emits a KxK neighbourhood window per valid centre pixel (crop border mode).
- Has full ready/valid backpressure, row/frame markers, an end-of-frame interrupt and a sticky framing-error flag.
- Replaces per-stage instances between kernels.

Parameters:
- PIX_W, 8, pixel width in bits.
- IMG_W, 512, pixels per line, at least K.
- IMG_H, 512, lines per frame, at least K.
- K, 3, window size; odd, 3 to 7.

Ports:
- axi_clk  in  1  clock; all logic rising-edge.
- axi_reset_n  in  1  reset, asynchronous, active-low.
- s_axis_tvalid  in  1  input pixel valid.
- s_axis_tready  out  1  input ready.
- s_axis_tdata  in  PIX_W  input pixel.
- s_axis_tuser  in  1  start of frame; marks pixel (0,0).
- s_axis_tlast  in  1  end of line.
- m_valid  out  1  window valid.
- m_ready  in  1  downstream ready.
- m_window  out  K*K*PIX_W  element (i,j) at bits [(i*K+j)*PIX_W +: PIX_W]; i=0 is the top (oldest) row, j=0 is the leftmost column.
- m_last  out  1  last window of a line.
- m_eof  out  1  last window of the frame.
- i_err_clr  in  1  clears o_err.
- o_err  out  1  sticky framing error.
- o_intr  out  1  one-cycle pulse at end of frame.

Behaviour:
- Reset values: s_axis_tready=1 (combinational); m_valid, m_last, m_eof, o_err, o_intr all 0; m_window all 0; row/col counters 0.
- Line-buffer RAM contents are not cleared and are don't-care.
- Handshake:
  - s_axis_tready = !m_valid || m_ready.
  - acc = s_axis_tvalid && s_axis_tready.
  - Output holds m_window, m_last and m_eof stable while m_valid && !m_ready.
- Storage:
  - K-1 cascaded line buffers, each IMG_W x PIX_W, with asynchronous read and synchronous write (read-old-data).
  - On acc at column col: LB0 writes the input pixel, and LBn writes LB(n-1)'s old word at col.
  - The input pixel is row r; LBn output is row r-1-n.
  - K column shift registers, each K-1 deep, shift on acc.
- Window condition: r >= K-1 and col >= K-1. The window covers rows r-K+1..r and columns col-K+1..col.
- Output register timing:
  - On acc with the window condition true: next cycle m_valid=1, m_window holds the window, m_last=(col==IMG_W-1), m_eof=m_last&&(r==IMG_H-1). Latency is 1 cycle.
  - Otherwise, if m_ready: m_valid goes to 0.
- Windows per frame = (IMG_W-K+1)*(IMG_H-K+1).
- Counters:
  - On acc, col increments.
  - At col==IMG_W-1: col returns to 0 and r increments.
  - At r==IMG_H-1: r returns to 0, and o_intr pulses high for the cycle after that acc.
- Framing errors (all set o_err, which is sticky):
  - tlast with col != IMG_W-1: that pixel is treated as the line end; col=0 and r increments next.
  - col==IMG_W-1 without tlast: line ends anyway.
  - tuser with (r,col) != (0,0): the pixel is taken as (0,0); counters restart; no windows until row K-1 of the new frame.
  - tuser at (0,0) is normal.
- o_err clears one cycle after i_err_clr=1. If an error and a clear occur in the same cycle, the error wins.
- Asynchronous reset mid-frame: outputs go to reset values immediately, and any pending window is dropped.

Decomposition:
- Package stream_window_pkg:
  - constant function clog2;
  - COL_W = clog2(IMG_W) and ROW_W = clog2(IMG_H) derivation helpers;
  - window index function idx(i,j) = (i*K+j)*PIX_W.
- One sub-module, line_buffer: parameters DEPTH and WIDTH; ports axi_clk, wr_en, addr, din, dout (asynchronous read, read-old-data). Instantiated K-1 times.

Test Plan:
Bench parameters IMG_W=8, IMG_H=6, K=3; pixel value = r*16+c.
1. Full frame, m_ready=1, continuous valid -> exactly 24 windows.
   - First window = {00,01,02,10,11,12,20,21,22}, m_valid 1 cycle after pixel (2,2) is accepted.
   - m_last on columns 7; m_eof on window 24.
   - o_intr high 1 cycle after pixel (5,7).
2. m_ready low 5 cycles while m_valid=1 -> m_window stable and s_axis_tready=0; output sequence identical to scenario 1.
3. tlast at row 1 col 5 -> o_err=1; next pixel is counted as (2,0); i_err_clr pulse -> o_err=0 next cycle.
4. tuser at row 3 col 2 -> o_err=1, counters restart; no m_valid until new-frame pixel (2,2), whose window is {00..22} of the new frame.
5. axi_reset_n low mid-row 4 with m_valid=1 -> m_valid=0 and s_axis_tready=1 immediately; the following full frame gives 24 correct windows.
6. Re-elaborate with K=5 -> 8 windows; first window is 0x00..0x44 row-major, emitted after pixel (4,4).

Source files
------------

// File: rtl/stream_window_pkg.sv
// rtl/stream_window_pkg.sv - shared width and window-index helpers for stream_window_gen
package stream_window_pkg;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) begin
            r++;
        end
        return r;
    endfunction

    // Counters and addresses are never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

    function automatic int col_w(input int img_w);
        return cnt_w(img_w);
    endfunction

    function automatic int row_w(input int img_h);
        return cnt_w(img_h);
    endfunction

    function automatic int idx(input int i, input int j, input int k, input int pix_w);
        return (i * k + j) * pix_w;
    endfunction

endpackage

// File: rtl/stream_window_gen_line_buffer.sv
// rtl/stream_window_gen_line_buffer.sv - one line of pixel storage, async read, sync write
module line_buffer
    import stream_window_pkg::*;
#(
    parameter int DEPTH = 512,
    parameter int WIDTH = 8
) (
    input  logic                    axi_clk,
    input  logic                    wr_en,
    input  logic [cnt_w(DEPTH)-1:0] addr,
    input  logic [WIDTH-1:0]        din,
    output logic [WIDTH-1:0]        dout
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Read sees the word before this cycle's write, which is what lets buffers cascade.
    assign dout = mem_q[addr];

    always_ff @(posedge axi_clk) begin
        if (wr_en) begin
            mem_q[addr] <= din;
        end
    end

endmodule

// File: rtl/stream_window_gen.sv
// rtl/stream_window_gen.sv - KxK neighbourhood window generator over an AXI-stream pixel stream
module stream_window_gen
    import stream_window_pkg::*;
#(
    parameter int PIX_W = 8,
    parameter int IMG_W = 512,
    parameter int IMG_H = 512,
    parameter int K     = 3
) (
    input  logic                 axi_clk,
    input  logic                 axi_reset_n,
    input  logic                 s_axis_tvalid,
    output logic                 s_axis_tready,
    input  logic [PIX_W-1:0]     s_axis_tdata,
    input  logic                 s_axis_tuser,
    input  logic                 s_axis_tlast,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [K*K*PIX_W-1:0] m_window,
    output logic                 m_last,
    output logic                 m_eof,
    input  logic                 i_err_clr,
    output logic                 o_err,
    output logic                 o_intr
);

    localparam int COL_W = col_w(IMG_W);
    localparam int ROW_W = row_w(IMG_H);
    localparam logic [COL_W-1:0] COL_MAX = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(IMG_H - 1);
    localparam logic [COL_W-1:0] COL_WIN = COL_W'(K - 1);
    localparam logic [ROW_W-1:0] ROW_WIN = ROW_W'(K - 1);

    logic [COL_W-1:0]     col_q, col_d, eff_col;
    logic [ROW_W-1:0]     row_q, row_d, eff_row;
    logic                 acc, at_col_max, line_end, frame_end, win_ok, sof_err, frame_err;
    logic [PIX_W-1:0]     lb_din  [K-1];
    logic [PIX_W-1:0]     lb_dout [K-1];
    logic [PIX_W-1:0]     col_vec [K];
    logic [PIX_W-1:0]     sr_q    [K][K-1];
    logic [K*K*PIX_W-1:0] win_cur, win_q, win_d;
    logic                 m_valid_q, m_valid_d, m_last_q, m_last_d, m_eof_q, m_eof_d;
    logic                 err_q, err_d, intr_q, intr_d;

    assign s_axis_tready = !m_valid_q || m_ready;
    assign acc           = s_axis_tvalid && s_axis_tready;

    // A start-of-frame marker anywhere forces this pixel to position (0,0).
    always_comb begin
        sof_err    = s_axis_tuser && ((row_q != '0) || (col_q != '0));
        eff_col    = s_axis_tuser ? '0 : col_q;
        eff_row    = s_axis_tuser ? '0 : row_q;
        at_col_max = (eff_col == COL_MAX);
        line_end   = s_axis_tlast || at_col_max;
        frame_end  = line_end && (eff_row == ROW_MAX);
        win_ok     = (eff_row >= ROW_WIN) && (eff_col >= COL_WIN);
        frame_err  = sof_err || (s_axis_tlast != at_col_max);
    end

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (acc) begin
            if (line_end) begin
                col_d = '0;
                row_d = (eff_row == ROW_MAX) ? '0 : eff_row + ROW_W'(1);
            end else begin
                col_d = eff_col + COL_W'(1);
                row_d = eff_row;
            end
        end
    end

    always_comb begin
        lb_din[0] = s_axis_tdata;
        for (int n = 1; n < K - 1; n++) begin
            lb_din[n] = lb_dout[n-1];
        end
    end

    for (genvar n = 0; n < K - 1; n++) begin : g_lb
        line_buffer #(
            .DEPTH(IMG_W),
            .WIDTH(PIX_W)
        ) u_lb (
            .axi_clk(axi_clk),
            .wr_en  (acc),
            .addr   (eff_col),
            .din    (lb_din[n]),
            .dout   (lb_dout[n])
        );
    end

    // Window row K-1 is the live pixel; buffer n holds the row n+1 lines above it.
    always_comb begin
        col_vec[K-1] = s_axis_tdata;
        for (int i = 0; i < K - 1; i++) begin
            col_vec[i] = lb_dout[K-2-i];
        end
    end

    always_ff @(posedge axi_clk) begin
        if (acc) begin
            for (int i = 0; i < K; i++) begin
                sr_q[i][0] <= col_vec[i];
                for (int m = 1; m < K - 1; m++) begin
                    sr_q[i][m] <= sr_q[i][m-1];
                end
            end
        end
    end

    always_comb begin
        win_cur = '0;
        for (int i = 0; i < K; i++) begin
            for (int j = 0; j < K; j++) begin
                if (j == K - 1) begin
                    win_cur[idx(i, j, K, PIX_W) +: PIX_W] = col_vec[i];
                end else begin
                    win_cur[idx(i, j, K, PIX_W) +: PIX_W] = sr_q[i][K-2-j];
                end
            end
        end
    end

    always_comb begin
        m_valid_d = m_valid_q;
        m_last_d  = m_last_q;
        m_eof_d   = m_eof_q;
        win_d     = win_q;
        if (acc && win_ok) begin
            m_valid_d = 1'b1;
            m_last_d  = at_col_max;
            m_eof_d   = at_col_max && (eff_row == ROW_MAX);
            win_d     = win_cur;
        end else if (m_ready) begin
            m_valid_d = 1'b0;
        end
    end

    // A new framing error outranks a simultaneous clear.
    always_comb begin
        err_d  = err_q;
        intr_d = acc && frame_end;
        if (acc && frame_err) begin
            err_d = 1'b1;
        end else if (i_err_clr) begin
            err_d = 1'b0;
        end
    end

    always_ff @(posedge axi_clk or negedge axi_reset_n) begin
        if (!axi_reset_n) begin
            col_q     <= '0;
            row_q     <= '0;
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
            m_eof_q   <= 1'b0;
            win_q     <= '0;
            err_q     <= 1'b0;
            intr_q    <= 1'b0;
        end else begin
            col_q     <= col_d;
            row_q     <= row_d;
            m_valid_q <= m_valid_d;
            m_last_q  <= m_last_d;
            m_eof_q   <= m_eof_d;
            win_q     <= win_d;
            err_q     <= err_d;
            intr_q    <= intr_d;
        end
    end

    assign m_valid  = m_valid_q;
    assign m_window = win_q;
    assign m_last   = m_last_q;
    assign m_eof    = m_eof_q;
    assign o_err    = err_q;
    assign o_intr   = intr_q;

endmodule

// File: tb/tb_stream_window_gen.sv
// tb/tb_stream_window_gen.sv - self-checking bench for stream_window_gen with K=3 and K=5 instances
module tb_stream_window_gen;

    logic         axi_clk;
    logic         axi_reset_n;
    logic         s_axis_tvalid, s_axis_tuser, s_axis_tlast;
    logic [7:0]   s_axis_tdata;
    logic         m_ready, i_err_clr;
    logic         s_axis_tready3, m_valid3, m_last3, m_eof3, o_err3, o_intr3;
    logic [71:0]  m_window3;
    logic         tvalid5, s_axis_tready5, m_valid5, m_last5, m_eof5, o_err5, o_intr5;
    logic         m_ready5;
    logic [199:0] m_window5;

    typedef struct {
        logic [199:0] win;
        bit           last;
        bit           eof;
        int           cyc;
    } sb_t;

    typedef struct {
        bit vld;
        int r;
        int c;
        bit user;
        bit last;
        bit clr;
        bit exp_err;
    } err_vec_t;

    sb_t      q3[$];
    sb_t      q5[$];
    err_vec_t tv[8];
    int       n_checks, n_errors, cyc, cur_r, cur_c, n_win3, n_win5, base3, base5;
    bit       acc_q, exp_intr, seen3, seen5;
    logic [71:0] held;

    stream_window_gen #(.PIX_W(8), .IMG_W(8), .IMG_H(6), .K(3)) dut3 (
        .axi_clk(axi_clk), .axi_reset_n(axi_reset_n),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready3),
        .s_axis_tdata(s_axis_tdata), .s_axis_tuser(s_axis_tuser), .s_axis_tlast(s_axis_tlast),
        .m_valid(m_valid3), .m_ready(m_ready), .m_window(m_window3),
        .m_last(m_last3), .m_eof(m_eof3),
        .i_err_clr(i_err_clr), .o_err(o_err3), .o_intr(o_intr3)
    );

    // The K=5 instance consumes exactly the pixels the K=3 instance accepts.
    assign tvalid5  = s_axis_tvalid && s_axis_tready3;
    assign m_ready5 = 1'b1;

    stream_window_gen #(.PIX_W(8), .IMG_W(8), .IMG_H(6), .K(5)) dut5 (
        .axi_clk(axi_clk), .axi_reset_n(axi_reset_n),
        .s_axis_tvalid(tvalid5), .s_axis_tready(s_axis_tready5),
        .s_axis_tdata(s_axis_tdata), .s_axis_tuser(s_axis_tuser), .s_axis_tlast(s_axis_tlast),
        .m_valid(m_valid5), .m_ready(m_ready5), .m_window(m_window5),
        .m_last(m_last5), .m_eof(m_eof5),
        .i_err_clr(i_err_clr), .o_err(o_err5), .o_intr(o_intr5)
    );

    initial axi_clk = 1'b0;
    always #5 axi_clk = ~axi_clk;

    task automatic check(input bit ok, input string name, input logic [199:0] act, input logic [199:0] exp);
        n_checks++;
        if (!ok) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [199:0] exp_win(input int k, input int r, input int c);
        logic [199:0] w;
        w = '0;
        for (int i = 0; i < k; i++) begin
            for (int j = 0; j < k; j++) begin
                w[(i * k + j) * 8 +: 8] = 8'((r - k + 1 + i) * 16 + (c - k + 1 + j));
            end
        end
        return w;
    endfunction

    // Compare what the DUTs present now, then record what this cycle's accepted pixel should produce.
    always @(negedge axi_clk) begin
        cyc++;
        if (axi_reset_n) begin
            if (m_valid3) begin
                if (q3.size() == 0) begin
                    check(1'b0, "k3_unexpected_valid", {128'b0, m_window3}, '0);
                end else begin
                    check(m_window3 == q3[0].win[71:0], "k3_window", {128'b0, m_window3}, q3[0].win);
                    check(m_last3 == q3[0].last, "k3_last", 200'(m_last3), 200'(q3[0].last));
                    check(m_eof3 == q3[0].eof, "k3_eof", 200'(m_eof3), 200'(q3[0].eof));
                    if (!seen3) begin
                        check(cyc == q3[0].cyc + 1, "k3_latency", 200'(cyc), 200'(q3[0].cyc + 1));
                        seen3 = 1'b1;
                    end
                    if (m_ready) begin
                        void'(q3.pop_front());
                        seen3 = 1'b0;
                        n_win3++;
                    end
                end
            end
            if (m_valid5) begin
                if (q5.size() == 0) begin
                    check(1'b0, "k5_unexpected_valid", m_window5, '0);
                end else begin
                    check(m_window5 == q5[0].win, "k5_window", m_window5, q5[0].win);
                    check(m_last5 == q5[0].last, "k5_last", 200'(m_last5), 200'(q5[0].last));
                    check(m_eof5 == q5[0].eof, "k5_eof", 200'(m_eof5), 200'(q5[0].eof));
                    if (!seen5) begin
                        check(cyc == q5[0].cyc + 1, "k5_latency", 200'(cyc), 200'(q5[0].cyc + 1));
                    end
                    void'(q5.pop_front());
                    seen5 = 1'b0;
                    n_win5++;
                end
            end
            check(o_intr3 == exp_intr, "k3_intr", 200'(o_intr3), 200'(exp_intr));
            check(o_intr5 == exp_intr, "k5_intr", 200'(o_intr5), 200'(exp_intr));
            exp_intr = 1'b0;
            acc_q = s_axis_tvalid && s_axis_tready3;
            if (acc_q) begin
                if (cur_r >= 2 && cur_c >= 2)
                    q3.push_back('{exp_win(3, cur_r, cur_c), cur_c == 7, cur_c == 7 && cur_r == 5, cyc});
                if (cur_r >= 4 && cur_c >= 4)
                    q5.push_back('{exp_win(5, cur_r, cur_c), cur_c == 7, cur_c == 7 && cur_r == 5, cyc});
                if (cur_r == 5 && cur_c == 7)
                    exp_intr = 1'b1;
            end
        end else begin
            acc_q = 1'b0;
        end
    end

    task automatic drive_pix(input int r, input int c, input bit user, input bit last);
        int t;
        cur_r         = r;
        cur_c         = c;
        s_axis_tdata  = 8'(r * 16 + c);
        s_axis_tuser  = user;
        s_axis_tlast  = last;
        s_axis_tvalid = 1'b1;
        t = 0;
        do begin
            @(posedge axi_clk);
            t++;
        end while (!acc_q && t < 50);
        #1;
        if (!acc_q) check(1'b0, "accept_timeout", 200'(t), 200'(50));
        s_axis_tvalid = 1'b0;
        s_axis_tuser  = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic send_range(input int r, input int c0, input int c1);
        for (int c = c0; c <= c1; c++) begin
            drive_pix(r, c, (r == 0 && c == 0), (c == 7));
        end
    endtask

    task automatic send_frame();
        for (int r = 0; r < 6; r++) begin
            send_range(r, 0, 7);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge axi_clk);
        #1;
    endtask

    task automatic do_reset();
        s_axis_tvalid = 1'b0;
        axi_reset_n   = 1'b0;
        q3.delete();
        q5.delete();
        seen3    = 1'b0;
        seen5    = 1'b0;
        exp_intr = 1'b0;
        repeat (2) @(posedge axi_clk);
        #3 axi_reset_n = 1'b1;
        @(posedge axi_clk);
        #1;
    endtask

    initial begin
        int tb_t;
        n_checks = 0; n_errors = 0; cyc = 0; n_win3 = 0; n_win5 = 0;
        cur_r = 0; cur_c = 0; acc_q = 0; exp_intr = 0; seen3 = 0; seen5 = 0;
        s_axis_tvalid = 0; s_axis_tuser = 0; s_axis_tlast = 0; s_axis_tdata = '0;
        m_ready = 1'b1; i_err_clr = 1'b0; axi_reset_n = 1'b0;

        // {vld, r, c, tuser, tlast, err_clr, expected o_err after the cycle}
        tv[0] = '{1, 0, 0, 1, 0, 0, 0};
        tv[1] = '{1, 0, 1, 0, 0, 0, 0};
        tv[2] = '{1, 0, 2, 0, 1, 0, 1};
        tv[3] = '{0, 0, 0, 0, 0, 0, 1};
        tv[4] = '{1, 1, 0, 0, 0, 1, 0};
        tv[5] = '{1, 0, 0, 1, 0, 1, 1};
        tv[6] = '{1, 0, 1, 0, 0, 1, 0};
        tv[7] = '{0, 0, 0, 0, 0, 0, 0};

        do_reset();
        check(m_valid3 == 0, "rst_m_valid", 200'(m_valid3), 0);
        check(s_axis_tready3 == 1, "rst_tready", 200'(s_axis_tready3), 1);
        check(m_last3 == 0 && m_eof3 == 0, "rst_last_eof", 200'({m_last3, m_eof3}), 0);
        check(o_err3 == 0 && o_intr3 == 0, "rst_err_intr", 200'({o_err3, o_intr3}), 0);
        check(m_window3 == '0, "rst_window", {128'b0, m_window3}, 0);
        check(m_valid5 == 0 && m_window5 == '0, "rst_k5", m_window5, 0);

        for (int i = 0; i < 8; i++) begin
            i_err_clr = tv[i].clr;
            if (tv[i].vld) drive_pix(tv[i].r, tv[i].c, tv[i].user, tv[i].last);
            else idle(1);
            i_err_clr = 1'b0;
            check(o_err3 == tv[i].exp_err, $sformatf("err_vec%0d", i), 200'(o_err3), 200'(tv[i].exp_err));
            check(o_err5 == tv[i].exp_err, $sformatf("err_vec%0d_k5", i), 200'(o_err5), 200'(tv[i].exp_err));
        end

        // Clean frame, downstream always ready.
        do_reset();
        base3 = n_win3; base5 = n_win5;
        send_frame();
        idle(4);
        check(n_win3 - base3 == 24, "frame1_k3_count", 200'(n_win3 - base3), 24);
        check(n_win5 - base5 == 8, "frame1_k5_count", 200'(n_win5 - base5), 8);
        check(o_err3 == 0, "frame1_no_err", 200'(o_err3), 0);

        // Same frame with a 5-cycle downstream stall.
        base3 = n_win3; base5 = n_win5;
        fork
            send_frame();
            begin
                tb_t = 0;
                while (n_win3 < base3 + 3 && tb_t < 500) begin
                    @(posedge axi_clk);
                    tb_t++;
                end
                #1;
                tb_t = 0;
                while (!m_valid3 && tb_t < 50) begin
                    @(posedge axi_clk);
                    #1;
                    tb_t++;
                end
                check(m_valid3 == 1, "bp_valid_seen", 200'(m_valid3), 1);
                held    = m_window3;
                m_ready = 1'b0;
                repeat (5) begin
                    @(negedge axi_clk);
                    check(m_valid3 == 1 && m_window3 == held, "bp_hold", {128'b0, m_window3}, {128'b0, held});
                    check(s_axis_tready3 == 0, "bp_tready", 200'(s_axis_tready3), 0);
                end
                @(posedge axi_clk);
                #1;
                m_ready = 1'b1;
            end
        join
        idle(4);
        check(n_win3 - base3 == 24, "frame2_k3_count", 200'(n_win3 - base3), 24);
        check(n_win5 - base5 == 8, "frame2_k5_count", 200'(n_win5 - base5), 8);

        // Early tlast on row 1: next pixel is (2,0).
        do_reset();
        base3 = n_win3;
        send_range(0, 0, 7);
        send_range(1, 0, 4);
        drive_pix(1, 5, 1'b0, 1'b1);
        check(o_err3 == 1, "short_line_err", 200'(o_err3), 1);
        send_range(2, 0, 5);
        idle(3);
        check(n_win3 - base3 == 4, "short_line_windows", 200'(n_win3 - base3), 4);
        check(o_err3 == 1, "err_sticky", 200'(o_err3), 1);
        i_err_clr = 1'b1;
        idle(1);
        i_err_clr = 1'b0;
        check(o_err3 == 0, "err_clear", 200'(o_err3), 0);

        // tuser at row 3 col 2 restarts the frame.
        do_reset();
        base3 = n_win3; base5 = n_win5;
        send_range(0, 0, 7);
        send_range(1, 0, 7);
        send_range(2, 0, 7);
        send_range(3, 0, 1);
        check(o_err3 == 0, "pre_sof_err", 200'(o_err3), 0);
        drive_pix(0, 0, 1'b1, 1'b0);
        check(o_err3 == 1, "mid_frame_sof_err", 200'(o_err3), 1);
        send_range(0, 1, 7);
        for (int r = 1; r < 6; r++) send_range(r, 0, 7);
        idle(4);
        check(n_win3 - base3 == 30, "restart_k3_count", 200'(n_win3 - base3), 30);
        check(n_win5 - base5 == 8, "restart_k5_count", 200'(n_win5 - base5), 8);
        i_err_clr = 1'b1;
        idle(1);
        i_err_clr = 1'b0;

        // Asynchronous reset mid row 4 with a window pending.
        for (int r = 0; r < 4; r++) send_range(r, 0, 7);
        send_range(4, 0, 4);
        check(m_valid3 == 1, "pre_reset_valid", 200'(m_valid3), 1);
        axi_reset_n = 1'b0;
        q3.delete();
        q5.delete();
        seen3 = 1'b0; seen5 = 1'b0; exp_intr = 1'b0;
        #1;
        check(m_valid3 == 0 && m_valid5 == 0, "async_rst_valid", 200'({m_valid3, m_valid5}), 0);
        check(s_axis_tready3 == 1, "async_rst_tready", 200'(s_axis_tready3), 1);
        repeat (2) @(posedge axi_clk);
        #3 axi_reset_n = 1'b1;
        @(posedge axi_clk);
        #1;
        base3 = n_win3; base5 = n_win5;
        send_frame();
        idle(4);
        check(n_win3 - base3 == 24, "post_rst_k3_count", 200'(n_win3 - base3), 24);
        check(n_win5 - base5 == 8, "post_rst_k5_count", 200'(n_win5 - base5), 8);

        check(q3.size() == 0, "k3_sb_empty", 200'(q3.size()), 0);
        check(q5.size() == 0, "k5_sb_empty", 200'(q5.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
